// File: rtl/owt_rx_ctrl.sv
// owt_rx_ctrl: one-wire-transfer receive controller.
// Hunts for a run of SYNC_LEN '1' symbols, then collects DATA_W payload bits
// (MSB first) and one even-parity bit. Each complete frame is reported with
// its parity status. Frames that stall in DATA or PAR are aborted by timeout.
module owt_rx_ctrl #(
    parameter int unsigned       DATA_W   = 16,
    parameter int unsigned       SYNC_LEN = 4,
    parameter int unsigned       TMO_W    = 12,
    parameter logic [TMO_W-1:0]  TMO_TH   = TMO_W'(2000)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_en,
    input  logic              i_sym_vld,
    input  logic              i_sym_data,
    output logic              o_frm_vld,
    output logic [DATA_W-1:0] o_frm_data,
    output logic              o_frm_err,
    output logic              o_tmo,
    output logic [7:0]        o_frm_cnt,
    output logic              o_busy
);

    localparam int unsigned BIT_W  = $clog2(DATA_W + 1);
    localparam int unsigned SYNC_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    state_t              state;
    logic [SYNC_W-1:0]   sync_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [TMO_W-1:0]    tmo_cnt;
    logic [DATA_W-1:0]   shreg;
    logic                tmo_hit;
    logic                last_sync;
    logic                last_bit;

    // Timer reaches its limit on this cycle when no strobe arrives.
    assign tmo_hit   = (tmo_cnt == (TMO_TH - TMO_W'(1)));
    // The current '1' strobe completes the preamble.
    assign last_sync = (sync_cnt == SYNC_W'(SYNC_LEN - 1));
    // The current strobe is the final payload bit.
    assign last_bit  = (bit_cnt == BIT_W'(DATA_W - 1));

    // Busy while a frame body (payload or parity) is being collected.
    assign o_busy = (state == DATA) || (state == PAR);

    // Receive FSM with counters and registered frame outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            sync_cnt   <= '0;
            bit_cnt    <= '0;
            tmo_cnt    <= '0;
            shreg      <= '0;
            o_frm_vld  <= 1'b0;
            o_frm_data <= '0;
            o_frm_err  <= 1'b0;
            o_tmo      <= 1'b0;
            o_frm_cnt  <= 8'd0;
        end else begin
            o_frm_vld <= 1'b0;
            o_tmo     <= 1'b0;

            if (!i_en) begin
                // Disable beats any strobe or timeout in the same cycle.
                state    <= IDLE;
                sync_cnt <= '0;
                bit_cnt  <= '0;
                tmo_cnt  <= '0;
                shreg    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= SYNC;
                        sync_cnt <= '0;
                    end

                    SYNC: begin
                        if (i_sym_vld) begin
                            if (i_sym_data) begin
                                if (last_sync) begin
                                    state    <= DATA;
                                    sync_cnt <= '0;
                                    bit_cnt  <= '0;
                                    tmo_cnt  <= '0;
                                    shreg    <= '0;
                                end else begin
                                    sync_cnt <= sync_cnt + SYNC_W'(1);
                                end
                            end else begin
                                sync_cnt <= '0;
                            end
                        end
                    end

                    DATA: begin
                        if (i_sym_vld) begin
                            shreg   <= {shreg[DATA_W-2:0], i_sym_data};
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            tmo_cnt <= '0;
                            if (last_bit) begin
                                state <= PAR;
                            end
                        end else if (tmo_hit) begin
                            o_tmo    <= 1'b1;
                            state    <= SYNC;
                            sync_cnt <= '0;
                            bit_cnt  <= '0;
                            tmo_cnt  <= '0;
                            shreg    <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end

                    PAR: begin
                        if (i_sym_vld) begin
                            o_frm_data <= shreg;
                            o_frm_err  <= ^{shreg, i_sym_data};
                            o_frm_vld  <= 1'b1;
                            o_frm_cnt  <= o_frm_cnt + 8'd1;
                            state      <= SYNC;
                            sync_cnt   <= '0;
                            bit_cnt    <= '0;
                            tmo_cnt    <= '0;
                        end else if (tmo_hit) begin
                            o_tmo    <= 1'b1;
                            state    <= SYNC;
                            sync_cnt <= '0;
                            bit_cnt  <= '0;
                            tmo_cnt  <= '0;
                            shreg    <= '0;
                        end else begin
                            tmo_cnt <= tmo_cnt + TMO_W'(1);
                        end
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_owt_rx_ctrl.sv
// Bench for owt_rx_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_owt_rx_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned SL = 4;
    localparam int unsigned TW = 12;
    localparam int unsigned TH = 2000;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          vld;
    logic          dat;
    logic          frm_vld;
    logic [DW-1:0] frm_data;
    logic          frm_err;
    logic          tmo;
    logic [7:0]    frm_cnt;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int vld_seen = 0;

    owt_rx_ctrl #(
        .DATA_W  (DW),
        .SYNC_LEN(SL),
        .TMO_W   (TW),
        .TMO_TH  (12'd2000)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_sym_vld (vld),
        .i_sym_data(dat),
        .o_frm_vld (frm_vld),
        .o_frm_data(frm_data),
        .o_frm_err (frm_err),
        .o_tmo     (tmo),
        .o_frm_cnt (frm_cnt),
        .o_busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (frame level, timestamps) -------------
    bit            m_ok = 0;
    bit            m_active;
    bit            m_inframe;
    int            m_ones;
    int            m_last;
    int            m_cyc = 0;
    bit            m_q[$];
    logic [DW-1:0] e_data;
    logic          e_err;
    logic          e_vld;
    logic          e_tmo;
    logic [7:0]    e_cnt;

    always @(posedge clk) begin
        m_cyc++;
        e_vld = 1'b0;
        e_tmo = 1'b0;
        if (rst) begin
            m_ok = 1; m_active = 0; m_inframe = 0; m_ones = 0;
            m_q.delete();
            e_data = '0; e_err = 1'b0; e_cnt = 8'd0;
        end else if (!en) begin
            m_active = 0; m_inframe = 0; m_ones = 0;
            m_q.delete();
        end else if (!m_active) begin
            m_active = 1; m_ones = 0;
        end else if (m_inframe) begin
            if (vld) begin
                if (m_q.size() < DW) begin
                    m_q.push_back(dat);
                    m_last = m_cyc;
                end else begin
                    int ones;
                    logic [DW-1:0] val;
                    ones = dat ? 1 : 0;
                    val = '0;
                    foreach (m_q[i]) begin
                        val = {val[DW-2:0], m_q[i]};
                        if (m_q[i]) ones++;
                    end
                    e_data = val;
                    e_err  = (ones % 2) == 1;
                    e_vld  = 1'b1;
                    e_cnt  = e_cnt + 8'd1;
                    m_inframe = 0; m_ones = 0;
                    m_q.delete();
                end
            end else if (m_cyc - m_last == TH) begin
                e_tmo = 1'b1;
                m_inframe = 0; m_ones = 0;
                m_q.delete();
            end
        end else if (vld) begin
            if (dat) begin
                m_ones++;
                if (m_ones == SL) begin
                    m_inframe = 1;
                    m_q.delete();
                    m_last = m_cyc;
                end
            end else begin
                m_ones = 0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(posedge clk) begin
        #1;
        if (m_ok) begin
            chk("frm_vld", 32'(frm_vld), 32'(e_vld));
            chk("tmo", 32'(tmo), 32'(e_tmo));
            chk("busy", 32'(busy), 32'(m_inframe));
            chk("frm_cnt", 32'(frm_cnt), 32'(e_cnt));
            chk("frm_data", 32'(frm_data), 32'(e_data));
            chk("frm_err", 32'(frm_err), 32'(e_err));
            if (frm_vld === 1'b1) vld_seen++;
        end
    end

    // ---------------- stimulus helpers ---------------------------------------
    task automatic send(input bit b);
        @(negedge clk);
        vld = 1'b1;
        dat = b;
    endtask

    task automatic quiet(input int n);
        repeat (n) begin
            @(negedge clk);
            vld = 1'b0;
            dat = 1'b0;
        end
    endtask

    task automatic send_sync();
        repeat (SL) send(1'b1);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send(w[i]);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    // Call right after the last strobe was issued; measures the gap to o_tmo.
    task automatic measure_tmo(input string name, input int exp_gap);
        int k;
        int got;
        @(posedge clk);
        #1;
        k = cyc;
        got = -1;
        for (int i = 0; i < exp_gap + 20; i++) begin
            @(negedge clk);
            vld = 1'b0;
            dat = 1'b0;
            if (tmo === 1'b1) begin
                got = cyc - k;
                break;
            end
        end
        chk(name, 32'(got), 32'(exp_gap));
        chk({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        logic [15:0] w;
        rst = 1'b1; en = 1'b0; vld = 1'b0; dat = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_vld", 32'(frm_vld), 32'd0);
        chk("rst_data", 32'(frm_data), 32'd0);
        chk("rst_cnt", 32'(frm_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        en = 1'b1;
        quiet(2);

        // Good frame
        send_sync();
        send_bits(32'hA5C3, 16);
        send(1'b0);
        after_edge();
        chk("good_vld", 32'(frm_vld), 32'd1);
        chk("good_data", 32'(frm_data), 32'hA5C3);
        chk("good_err", 32'(frm_err), 32'd0);
        chk("good_cnt", 32'(frm_cnt), 32'd1);

        // Parity error, back-to-back
        send_sync();
        send_bits(32'hA5C3, 16);
        send(1'b1);
        after_edge();
        chk("perr_vld", 32'(frm_vld), 32'd1);
        chk("perr_data", 32'(frm_data), 32'hA5C3);
        chk("perr_err", 32'(frm_err), 32'd1);
        chk("perr_cnt", 32'(frm_cnt), 32'd2);
        quiet(3);

        // Sync restart
        repeat (3) send(1'b1);
        after_edge();
        chk("restart_busy3", 32'(busy), 32'd0);
        send(1'b0);
        repeat (3) send(1'b1);
        after_edge();
        chk("restart_busy7", 32'(busy), 32'd0);
        send(1'b1);
        after_edge();
        chk("restart_busy8", 32'(busy), 32'd1);

        // Timeout after 5 data bits
        send_bits(32'h15, 5);
        measure_tmo("tmo_gap", TH);
        chk("tmo_cnt_hold", 32'(frm_cnt), 32'd2);

        // Strobe at 1999 cycles suppresses the timeout
        send_sync();
        send_bits(32'h0A, 5);
        quiet(1998);
        send(1'b1);
        measure_tmo("tmo_gap_1999", TH);

        // Strobe in the very cycle of the timeout wins
        send_sync();
        send_bits(32'h0A, 5);
        quiet(1999);
        send(1'b0);
        measure_tmo("tmo_gap_2000", TH);
        chk("tmo_data_hold", 32'(frm_data), 32'hA5C3);

        // Disable after 10 data bits
        send_sync();
        send_bits(32'h2AA, 10);
        @(negedge clk);
        en = 1'b0; vld = 1'b0;
        after_edge();
        chk("dis_busy", 32'(busy), 32'd0);
        chk("dis_vld", 32'(frm_vld), 32'd0);
        chk("dis_tmo", 32'(tmo), 32'd0);
        @(negedge clk);
        en = 1'b1;
        quiet(2);

        // Disable coinciding with the parity strobe
        send_sync();
        send_bits(32'h1234, 16);
        @(negedge clk);
        en = 1'b0; vld = 1'b1; dat = 1'b1;
        after_edge();
        chk("dispar_vld", 32'(frm_vld), 32'd0);
        chk("dispar_cnt", 32'(frm_cnt), 32'd2);
        @(negedge clk);
        en = 1'b1; vld = 1'b0; dat = 1'b0;
        quiet(2);

        // Reset while in PAR
        send_sync();
        send_bits(32'hFFFF, 16);
        after_edge();
        chk("par_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1; vld = 1'b1; dat = 1'b0;
        after_edge();
        chk("rstpar_vld", 32'(frm_vld), 32'd0);
        chk("rstpar_data", 32'(frm_data), 32'd0);
        chk("rstpar_err", 32'(frm_err), 32'd0);
        chk("rstpar_tmo", 32'(tmo), 32'd0);
        chk("rstpar_cnt", 32'(frm_cnt), 32'd0);
        chk("rstpar_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0; vld = 1'b0;
        quiet(2);

        // 256 back-to-back good frames wrap the counter
        base = vld_seen;
        for (int f = 0; f < 256; f++) begin
            w = 16'($urandom);
            send_sync();
            send_bits(32'(w), 16);
            send(^w);
        end
        after_edge();
        chk("wrap_cnt", 32'(frm_cnt), 32'd0);
        chk("wrap_frames", 32'(vld_seen - base), 32'd256);
        chk("wrap_err", 32'(frm_err), 32'd0);
        quiet(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/owt_rx_ctrl.md
# owt_rx_ctrl

One-wire-transfer (OWT) receive controller. It sits directly behind the OWT-mode symbol detector and consumes the detector's one-cycle symbol strobes (`o_vld` / `o_vld_data`). It hunts for a sync preamble, assembles a fixed-width data word followed by an even-parity bit, and reports each frame with error status. Per-frame timeout protection aborts stalled frames.

## Interface
Parameters:
- `DATA_W`, 16: payload bits per frame, MSB first; legal range 2..32.
- `SYNC_LEN`, 4: number of consecutive `1` symbols forming the preamble; legal range 1..15.
- `TMO_W`, 12: timeout counter width.
- `TMO_TH`, `TMO_W'(2000)`: symbol-free cycles allowed inside a frame before abort; must be ≥2.

Ports:
- `i_clk`, input, 1: the single clock.
- `i_rst`, input, 1: reset, synchronous, active-high.
- `i_en`, input, 1: receiver enable, level-sensitive.
- `i_sym_vld`, input, 1: symbol strobe from the detector's `o_vld`; one cycle per symbol.
- `i_sym_data`, input, 1: symbol value from the detector's `o_vld_data`; qualified by `i_sym_vld`.
- `o_frm_vld`, output, 1: one-cycle pulse when a complete frame is received.
- `o_frm_data`, output, `DATA_W`: received payload; held stable until the next `o_frm_vld`.
- `o_frm_err`, output, 1: parity error flag; valid with `o_frm_vld` and held with `o_frm_data`.
- `o_tmo`, output, 1: one-cycle pulse when a frame is aborted by timeout.
- `o_frm_cnt`, output, 8: count of `o_frm_vld` pulses; wraps 255→0.
- `o_busy`, output, 1: high while the state is DATA or PAR.

## Operation
- States: IDLE, SYNC, DATA, PAR.
- **IDLE:** symbols are ignored. When `i_en`=1, go to SYNC on the next cycle with `sync_cnt`=0.
- **SYNC:**
  - Each strobe with data=1 increments `sync_cnt`.
  - A strobe with data=0 clears `sync_cnt` to 0.
  - When a data=1 strobe makes `sync_cnt`==`SYNC_LEN`, go to DATA and clear `bit_cnt`, `tmo_cnt` and the shift register.
  - No timeout applies in SYNC.
- **DATA:**
  - Each strobe shifts `shreg <= {shreg[DATA_W-2:0], i_sym_data}` and increments `bit_cnt`.
  - The strobe that makes `bit_cnt`==`DATA_W` moves the state to PAR.
- **PAR:** the next strobe is the parity bit `p`. On that strobe:
  - `o_frm_data <= shreg`.
  - `o_frm_err <= ^{shreg, p}` (even parity; a result of 1 is an error).
  - Pulse `o_frm_vld`.
  - Increment `o_frm_cnt`.
  - Go to SYNC with `sync_cnt`=0.
- **Timeout (DATA and PAR only):**
  - `tmo_cnt` clears on every accepted strobe; otherwise it increments each cycle.
  - In a cycle with no strobe and `tmo_cnt`==`TMO_TH-1`: pulse `o_tmo`, discard the partial frame, go to SYNC with `sync_cnt`=0.
  - `o_frm_*` and `o_frm_cnt` are unchanged by a timeout.
- **Disable:** `i_en`=0 in any state forces IDLE on the next cycle.
  - The partial frame is discarded.
  - No `o_frm_vld` and no `o_tmo` are generated, even if a parity strobe or timeout occurs in that same cycle; disable has priority.
- **Priority, highest first:** `i_rst`, then `i_en`=0, then an accepted strobe, then timeout.

## Timing
- **Reset** (`i_rst`=1 at a rising edge) sets:
  - state to IDLE;
  - `sync_cnt`, `bit_cnt`, `tmo_cnt`, `shreg` to 0;
  - `o_frm_vld`, `o_frm_err`, `o_tmo` to 0;
  - `o_frm_data` to 0, `o_frm_cnt` to 0, `o_busy` to 0.
- Reset takes effect mid-frame with no output pulse.
- All outputs are registered except `o_busy`, which is decoded from the state register.
- **Frame latency:** `o_frm_vld`, `o_frm_data`, `o_frm_err` and the `o_frm_cnt` update appear in the cycle after the parity strobe is sampled.
- **Timeout latency:** `o_tmo` appears exactly `TMO_TH` cycles after the last accepted strobe (or after DATA entry). A strobe arriving in that same cycle wins and resets the timer.
- A strobe arriving in the cycle of the SYNC→DATA transition is the first data bit only if it is sampled after the transition, i.e. one cycle later. Back-to-back strobes on consecutive cycles must be supported.
- **Minimum frame:** `SYNC_LEN + DATA_W + 1` strobes. A new sync hunt starts the cycle after PAR, so `o_frm_vld` can recur every `SYNC_LEN + DATA_W + 1` strobes.

## Test plan
Defaults unless stated: `DATA_W`=16, `SYNC_LEN`=4, `TMO_TH`=2000.
- **Good frame:** `i_en`=1; strobes 1,1,1,1, then 0xA5C3 MSB first, then parity 0 → one `o_frm_vld` with `o_frm_data`=0xA5C3, `o_frm_err`=0, `o_frm_cnt`=1.
- **Parity error:** same frame with parity bit 1 → `o_frm_vld` with `o_frm_err`=1, data 0xA5C3, `o_frm_cnt`=2.
- **Sync restart:** strobes 1,1,1,0,1,1,1,1 → `o_busy` rises only after the 8th strobe, not after the 3rd.
- **Timeout:** after sync plus 5 data strobes, no strobes → `o_tmo` pulses exactly 2000 cycles after the 5th strobe, `o_busy`=0, no `o_frm_vld`. A strobe sent at cycle 1999 suppresses the timeout.
- **Disable/reset mid-frame:** drop `i_en` after 10 data bits → IDLE next cycle, no pulses. Separately, assert `i_rst` in PAR → all outputs 0 the next cycle.
- **Counter wrap:** 256 back-to-back good frames on consecutive-cycle strobes → `o_frm_cnt` returns to 0, and every frame is reported.
